// File: rtl/param_counter_pkg.sv
// param_counter_pkg: shared encodings for the parameterised counter.
// Holds the mode encodings and the one-shot FSM state type.
package param_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/param_counter_prescaler.sv
// param_counter_prescaler: enable divider, one tick every div+1 enabled cycles.
// Ports: clk, rst_n (sync, active-low), en, clr, div -> tick.
module param_counter_prescaler
    import param_counter_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en && (pcnt == div);

    // A shrunk divisor can leave pcnt above div; restart the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr || (pcnt > div)) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_counter.sv
// param_counter: up/down counter with wrap, saturate and one-shot modes.
// Ports: clk, rst_n (sync, active-low), en, dir, mode, limit, load,
//        load_val, start, div -> count, tc, busy, done.
// Macro PARAM_COUNTER_PRESCALE_EN enables the div+1 prescaler.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic [PRESCALE_W-1:0] div,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] stepped;
    logic             tc_n;
    logic             tick;
    logic             is_os;
    logic             is_sat;
    logic             at_term;
    logic             restart;
    logic             pclr;
    logic             stepping;

    assign is_os    = (mode == MODE_ONESHOT);
    assign is_sat   = (mode == MODE_SAT);
    assign term     = dir ? limit : '0;
    assign at_term  = (count == term);
    assign stepped  = dir ? count + 1'b1 : count - 1'b1;
    assign restart  = start && is_os && !load;
    assign pclr     = load || restart;
    assign stepping = en && tick && !pclr &&
                      (!is_os || (state == RUN));

`ifdef PARAM_COUNTER_PRESCALE_EN
    param_counter_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (pclr),
        .div  (div),
        .tick (tick)
    );
`else
    logic unused_div;
    assign unused_div = ^div;
    assign tick       = 1'b1;
`endif

    always_comb begin
        state_n = state;
        count_n = count;
        tc_n    = 1'b0;
        if (load) begin
            count_n = load_val;
            state_n = IDLE;
        end else if (restart) begin
            count_n = dir ? '0 : limit;
            state_n = RUN;
        end else begin
            if (!is_os) begin
                state_n = IDLE;
            end
            if (stepping) begin
                unique case (1'b1)
                    is_os: begin
                        // Already at terminal (e.g. limit=0) ends the run.
                        if (!at_term) begin
                            count_n = stepped;
                        end
                        if (at_term || (stepped == term)) begin
                            state_n = DONE;
                            tc_n    = 1'b1;
                        end
                    end
                    is_sat: begin
                        if (!at_term) begin
                            count_n = stepped;
                            tc_n    = (stepped == term);
                        end
                    end
                    default: begin
                        if (at_term) begin
                            count_n = dir ? '0 : limit;
                        end else begin
                            count_n = stepped;
                        end
                        tc_n = (count_n == term);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            tc    <= tc_n;
        end
    end

    assign busy = is_os ? (state == RUN) : en;
    assign done = is_os && (state == DONE);

endmodule
